sync2_edge_sync: RTL and testbench
==================================

Name: sync2_edge_sync

Overview:
- Multi-flop clock-domain-crossing synchronizer with optional rising/falling edge detection.
- Brings asynchronous level signals into the local clock domain, e.g. a QSPI transaction-done flag or chip-enable-deasserted flag.
- Emits single-cycle pulses on edges of the synchronized value, e.g. a word strobe that advances a control FSM.
- One block covers both the plain synchronizer use and the synchronizer-plus-edge-detect use.

Parameters:
- WIDTH, 1, number of independent bits synchronized in parallel.
- STAGES, 2, synchronizer flop depth; legal values 2..4; any other value is an elaboration error.
- R, 0, reset value of every flop. 1-bit value, replicated across WIDTH.
- EDGE_EN, 1, when 1 the pe/ne outputs are generated; when 0 pe and ne are tied to 0.

Ports:
- clk, input, 1, local clock; all flops update on its rising edge.
- rst, input, 1, asynchronous active-high reset.
- d, input, WIDTH, asynchronous level input from the foreign domain.
- q, output, WIDTH, synchronized copy of d.
- pe, output, WIDTH, one-cycle rising-edge pulse of q.
- ne, output, WIDTH, one-cycle falling-edge pulse of q.

Behaviour:
- Structure per bit: chain s[0..STAGES-1] plus history flop h.
  - Each rising clk edge: s[0]<=d, s[i]<=s[i-1], h<=s[STAGES-1].
  - q = s[STAGES-1], driven straight from a flop output; no logic after it.
- Reset:
  - rst=1 asynchronously forces every s[i] and h to R, with no clock edge needed.
  - While rst is held, q=R and pe=ne=0.
  - Release is sampled normally on the next clk edge.
- Latency: a change on d that meets setup before edge N appears on q after edge N+STAGES-1.
  - Default STAGES=2: two rising edges from d change to q change.
- Edge outputs, combinational from registered state only:
  - pe = q & ~h
  - ne = ~q & h
  - Each pulse is exactly one clk period wide, in the first cycle q shows the new value.
  - pe and ne are never both high on the same bit.
- Because h resets to R together with the chain, no spurious pe/ne occurs after reset.
  - Exception: d differs from R at release. The transition then propagates normally and produces one legitimate edge pulse.
- Pulses on d narrower than one clk period may be lost. This is acceptable; the source must hold levels at least STAGES+1 cycles for guaranteed capture.
- A toggle on d every cycle yields alternating pe/ne pulses on consecutive cycles after latency. No merging or suppression.
- Bits of a WIDTH>1 vector are independent. No coherence is guaranteed across bits; callers must use Gray or handshake encoding for multi-bit values.
- EDGE_EN=0: the h flop is removed; pe=ne={WIDTH{1'b0}}.
- rst asserted mid-propagation discards in-flight values immediately. q returns to R without generating pe/ne.
- Flops carry synchronizer attributes (ASYNC_REG / keep) so synthesis does not retime or merge the chain.

Test Plan:
- Default params, R=0: assert rst, set d=1, release rst; d held 1 → q rises exactly 2 edges after release, pe=1 for one cycle, ne stays 0.
- d 1→0 with WIDTH=1, STAGES=2 → q falls 2 edges later, ne=1 for one cycle, pe=0 throughout.
- R=1, d=1 through and after reset → q=1 from reset onward, no pe or ne ever.
- R=1, d=0 at release → q falls to 0 two edges after release, exactly one ne pulse, no pe.
- d toggled every 4 cycles for 20 cycles, STAGES=3 → q follows with 3-edge latency; pe count 3, ne count 2, each pulse 1 cycle.
- WIDTH=4: drive d=4'b1010 then 4'b0110 → pe=4'b0100 and ne=4'b1000 in the same cycle. Then assert rst asynchronously mid-cycle → q=4'b0000 before the next clk edge, no pulses.

Source files
------------

// File: rtl/sync2_edge_sync.sv
// Multi-flop CDC synchronizer for asynchronous level inputs, with optional
// single-cycle rising/falling edge pulses derived from the synchronized value.
module sync2_edge_sync #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned STAGES  = 2,
  parameter logic        R       = 1'b0,
  parameter bit          EDGE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] pe,
  output logic [WIDTH-1:0] ne
);

  localparam int unsigned      LAST    = STAGES - 1;
  localparam logic [WIDTH-1:0] RST_VAL = {WIDTH{R}};

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("sync2_edge_sync: STAGES must be in 2..4");
  end

  // Chain flops are tagged so synthesis keeps them adjacent and unretimed.
  (* ASYNC_REG = "TRUE", keep = "true" *) logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = d;
    for (int unsigned i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        sync_q[i] <= RST_VAL;
      end
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign q = sync_q[LAST];

  if (EDGE_EN) begin : g_edge
    // History resets with the chain so reset alone never yields a pulse.
    (* keep = "true" *) logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] hist_d;

    assign hist_d = sync_q[LAST];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hist_q <= RST_VAL;
      end else begin
        hist_q <= hist_d;
      end
    end

    assign pe = sync_q[LAST] & ~hist_q;
    assign ne = ~sync_q[LAST] & hist_q;
  end else begin : g_no_edge
    assign pe = '0;
    assign ne = '0;
  end

endmodule

// File: tb/tb_sync2_edge_sync.sv
// Self-checking bench for sync2_edge_sync: five parameterizations share one
// clock/reset and are compared every cycle against a sample-history model.
module tb_sync2_edge_sync;

  localparam int unsigned NDUT = 5;
  localparam int unsigned ST [NDUT] = '{2, 2, 3, 2, 4};
  localparam int unsigned WD [NDUT] = '{1, 1, 1, 4, 3};
  localparam logic        RV [NDUT] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam bit          EN [NDUT] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  typedef struct {
    logic rst;
    logic d;
    logic q;
    logic pe;
    logic ne;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] din [NDUT];
  logic [3:0] aq  [NDUT];
  logic [3:0] ape [NDUT];
  logic [3:0] ane [NDUT];

  logic       q0, pe0, ne0, q1, pe1, ne1, q2, pe2, ne2;
  logic [3:0] q3, pe3, ne3;
  logic [2:0] q4, pe4, ne4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync2_edge_sync #(.WIDTH(1), .STAGES(2), .R(1'b0), .EDGE_EN(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .d(din[0][0:0]), .q(q0), .pe(pe0), .ne(ne0));
  sync2_edge_sync #(.WIDTH(1), .STAGES(2), .R(1'b1), .EDGE_EN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .d(din[1][0:0]), .q(q1), .pe(pe1), .ne(ne1));
  sync2_edge_sync #(.WIDTH(1), .STAGES(3), .R(1'b0), .EDGE_EN(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .d(din[2][0:0]), .q(q2), .pe(pe2), .ne(ne2));
  sync2_edge_sync #(.WIDTH(4), .STAGES(2), .R(1'b0), .EDGE_EN(1'b1)) u_dut3 (
    .clk(clk), .rst(rst), .d(din[3]), .q(q3), .pe(pe3), .ne(ne3));
  sync2_edge_sync #(.WIDTH(3), .STAGES(4), .R(1'b1), .EDGE_EN(1'b0)) u_dut4 (
    .clk(clk), .rst(rst), .d(din[4][2:0]), .q(q4), .pe(pe4), .ne(ne4));

  assign aq[0] = 4'(q0);  assign ape[0] = 4'(pe0); assign ane[0] = 4'(ne0);
  assign aq[1] = 4'(q1);  assign ape[1] = 4'(pe1); assign ane[1] = 4'(ne1);
  assign aq[2] = 4'(q2);  assign ape[2] = 4'(pe2); assign ane[2] = 4'(ne2);
  assign aq[3] = q3;      assign ape[3] = pe3;     assign ane[3] = ne3;
  assign aq[4] = 4'(q4);  assign ape[4] = 4'(pe4); assign ane[4] = 4'(ne4);

  function automatic logic [3:0] mask(input int unsigned i);
    return 4'((1 << WD[i]) - 1);
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: hist[i][k] is the d value sampled k edges ago; q is the sample
  // from STAGES-1 edges ago, and an edge is q differing from the one before it.
  logic [3:0] hist [NDUT][5];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NDUT; i++) begin
      if (rst) begin
        for (int k = 0; k < 5; k++) hist[i][k] <= {4{RV[i]}} & mask(i);
      end else begin
        hist[i][0] <= din[i] & mask(i);
        for (int k = 1; k < 5; k++) hist[i][k] <= hist[i][k-1];
      end
    end
  end

  task automatic check_model();
    for (int i = 0; i < NDUT; i++) begin
      logic [3:0] eq, eh, epe, ene;
      eq  = hist[i][ST[i]-1];
      eh  = hist[i][ST[i]];
      epe = EN[i] ? (eq & ~eh) : 4'b0;
      ene = EN[i] ? (~eq & eh) : 4'b0;
      chk($sformatf("model_q_dut%0d", i), aq[i], eq);
      chk($sformatf("model_pe_dut%0d", i), ape[i], epe);
      chk($sformatf("model_ne_dut%0d", i), ane[i], ene);
    end
  endtask

  always begin
    @(posedge clk);
    #2;
    check_model();
  end

  // Observes bit 0 of one DUT for n edges after the current point.
  task automatic watch(input int i, input int n, input logic rv,
                       output int first_chg, output int np, output int nn);
    first_chg = -1;
    np = 0;
    nn = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (first_chg < 0 && aq[i][0] !== rv) first_chg = k;
      if (ape[i][0] === 1'b1) np++;
      if (ane[i][0] === 1'b1) nn++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    int   fc, np, nn, fpe, fne, rst_hold;

    for (int i = 0; i < NDUT; i++) din[i] = 4'b0;
    #1 rst = 1'b1;

    // Reset with d=1, release, hold, then drop d: rise then fall on dut0.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      rst    = tbl[v].rst;
      din[0] = {3'b0, tbl[v].d};
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_q", v),  aq[0],  {3'b0, tbl[v].q});
      chk($sformatf("vec%0d_pe", v), ape[0], {3'b0, tbl[v].pe});
      chk($sformatf("vec%0d_ne", v), ane[0], {3'b0, tbl[v].ne});
    end

    // R=1 with d=1 across reset: q stays 1, no pulses at all.
    @(negedge clk);
    rst    = 1'b1;
    din[1] = 4'b1;
    #1;
    chk("r1_hold_rst_q",  aq[1],  4'b1);
    chk("r1_hold_rst_pe", ape[1], 4'b0);
    chk("r1_hold_rst_ne", ane[1], 4'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    watch(1, 8, 1'b1, fc, np, nn);
    chk("r1_hold_no_change", 4'(fc + 1), 4'd0);
    chk("r1_hold_pe_count",  4'(np), 4'd0);
    chk("r1_hold_ne_count",  4'(nn), 4'd0);

    // R=1 with d=0 at release: q falls two edges later, one ne pulse.
    @(negedge clk);
    rst    = 1'b1;
    din[1] = 4'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    watch(1, 8, 1'b1, fc, np, nn);
    chk("r1_fall_latency",  4'(fc), 4'd2);
    chk("r1_fall_pe_count", 4'(np), 4'd0);
    chk("r1_fall_ne_count", 4'(nn), 4'd1);

    // STAGES=3, d toggled every 4 cycles for 20 cycles.
    @(negedge clk);
    rst    = 1'b1;
    din[2] = 4'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    np = 0; nn = 0; fpe = -1; fne = -1;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      if (c < 20 && (c % 4) == 0) din[2] = {3'b0, ~din[2][0]};
      @(posedge clk);
      #1;
      if (ape[2][0] === 1'b1) begin np++; if (fpe < 0) fpe = c; end
      if (ane[2][0] === 1'b1) begin nn++; if (fne < 0) fne = c; end
    end
    chk("s3_pe_count", 4'(np), 4'd3);
    chk("s3_ne_count", 4'(nn), 4'd2);
    chk("s3_first_pe", 4'(fpe), 4'd2);
    chk("s3_first_ne", 4'(fne), 4'd6);

    // WIDTH=4: simultaneous per-bit rise and fall, then async reset mid-cycle.
    @(negedge clk);
    rst    = 1'b1;
    din[3] = 4'b1010;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    din[3] = 4'b0110;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("w4_q",  aq[3],  4'b0110);
    chk("w4_pe", ape[3], 4'b0100);
    chk("w4_ne", ane[3], 4'b1000);
    #3;
    rst = 1'b1;
    #1;
    chk("w4_async_rst_q",  aq[3],  4'b0000);
    chk("w4_async_rst_pe", ape[3], 4'b0000);
    chk("w4_async_rst_ne", ane[3], 4'b0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Random levels on every DUT with occasional asynchronous resets.
    rst_hold = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b0;
      end
      for (int i = 0; i < NDUT; i++) begin
        if ($urandom_range(0, 1) == 1) din[i] = 4'($urandom) & mask(i);
      end
      if (!rst && $urandom_range(0, 39) == 0) begin
        #2;
        rst      = 1'b1;
        rst_hold = int'($urandom_range(1, 3));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
